cache_tag_ctrl_a: RTL and testbench

Processor-A cache controller stage that sits directly upstream of the synchronous-read tag RAM. It owns the tag RAM's addr/din/we and consumes its dout.
- Services CPU read/write requests by tag lookup and MSI state update.
- Issues bus transactions on misses, upgrades and victim write-backs.
- Handles snooped bus traffic.

---
 rtl/cache_tag_ctrl_a.sv | 171 +++++++++++++++++
 tb/tb_cache_tag_ctrl_a.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_tag_ctrl_a.sv
// cache_tag_ctrl_a: MSI tag-lookup controller in front of a synchronous-read tag RAM.
// Serves CPU requests and bus snoops, issuing fills, upgrades and victim write-backs.
module cache_tag_ctrl_a #(
    parameter int AWIDTH  = 3,
    parameter int TWIDTH  = 9,
    parameter int DWIDTH  = 11,
    parameter int PAWIDTH = TWIDTH + AWIDTH
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cpu_req,
    input  logic               cpu_rw,
    input  logic [PAWIDTH-1:0] cpu_addr,
    output logic               cpu_done,
    output logic               cpu_hit,
    input  logic               snp_valid,
    input  logic [1:0]         snp_cmd,
    input  logic [PAWIDTH-1:0] snp_addr,
    output logic               snp_ack,
    output logic               snp_flush,
    output logic               bus_req,
    output logic [1:0]         bus_cmd,
    output logic [PAWIDTH-1:0] bus_addr,
    input  logic               bus_done,
    output logic [AWIDTH-1:0]  tr_addr,
    output logic [DWIDTH-1:0]  tr_din,
    output logic               tr_we,
    input  logic [DWIDTH-1:0]  tr_dout
);
    localparam logic [1:0] ST_I = 2'b00, ST_S = 2'b01, ST_M = 2'b10;
    localparam logic [1:0] C_RD = 2'b00, C_RDX = 2'b01, C_UPGR = 2'b10, C_FLUSH = 2'b11;

    typedef enum logic [2:0] {IDLE, CMP, WB, BREQ, UPD, SCMP, SUPD} state_t;

    state_t             state;
    logic [PAWIDTH-1:0] addr_q;
    logic               rw_q;
    logic [1:0]         scmd_q;
    logic               flush_q;

    logic [TWIDTH-1:0]  req_tag, ram_tag;
    logic [AWIDTH-1:0]  req_idx;
    logic [1:0]         ram_st, snp_st, fill_cmd;
    logic               tag_eq, ram_valid, hit, take_snp, take_cpu, snp_wr, snp_fl;

    assign req_tag   = addr_q[PAWIDTH-1:AWIDTH];
    assign req_idx   = addr_q[AWIDTH-1:0];
    assign ram_tag   = tr_dout[DWIDTH-1:2];
    assign ram_st    = tr_dout[1:0];
    assign tag_eq    = ram_tag == req_tag;
    assign ram_valid = ram_st == ST_S || ram_st == ST_M;
    assign hit       = tag_eq && ram_valid;
    assign fill_cmd  = rw_q ? C_RDX : C_RD;

    // A request still high during its own completion pulse must not be taken again
    assign take_snp = snp_valid && !snp_ack;
    assign take_cpu = cpu_req && !cpu_done;

    // The RAM samples the index on the accepting edge, so the lookup is presented
    // combinationally while idle; otherwise the latched index is held
    assign tr_addr = reset           ? '0 :
                     state != IDLE   ? req_idx :
                     take_snp        ? snp_addr[AWIDTH-1:0] :
                     take_cpu        ? cpu_addr[AWIDTH-1:0] : '0;

    assign snp_wr = hit && (scmd_q == C_RD   ? ram_st == ST_M :
                            scmd_q == C_RDX  ? 1'b1 :
                            scmd_q == C_UPGR ? ram_st == ST_S : 1'b0);
    assign snp_fl = hit && ram_st == ST_M && (scmd_q == C_RD || scmd_q == C_RDX);
    assign snp_st = scmd_q == C_RD ? ST_S : ST_I;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            addr_q    <= '0;
            rw_q      <= 1'b0;
            scmd_q    <= 2'b00;
            flush_q   <= 1'b0;
            cpu_done  <= 1'b0;
            cpu_hit   <= 1'b0;
            snp_ack   <= 1'b0;
            snp_flush <= 1'b0;
            bus_req   <= 1'b0;
            bus_cmd   <= 2'b00;
            bus_addr  <= '0;
            tr_din    <= '0;
            tr_we     <= 1'b0;
        end else begin
            cpu_done  <= 1'b0;
            cpu_hit   <= 1'b0;
            snp_ack   <= 1'b0;
            snp_flush <= 1'b0;
            tr_we     <= 1'b0;
            case (state)
                IDLE: begin
                    if (take_snp) begin
                        addr_q <= snp_addr;
                        scmd_q <= snp_cmd;
                        state  <= SCMP;
                    end else if (take_cpu) begin
                        addr_q <= cpu_addr;
                        rw_q   <= cpu_rw;
                        state  <= CMP;
                    end
                end
                CMP: begin
                    if (hit && (!rw_q || ram_st == ST_M)) begin
                        cpu_done <= 1'b1;
                        cpu_hit  <= 1'b1;
                        state    <= IDLE;
                    end else if (hit) begin
                        bus_req  <= 1'b1;
                        bus_cmd  <= C_UPGR;
                        bus_addr <= addr_q;
                        state    <= BREQ;
                    end else if (ram_st == ST_M) begin
                        bus_req  <= 1'b1;
                        bus_cmd  <= C_FLUSH;
                        bus_addr <= {ram_tag, req_idx};
                        state    <= WB;
                    end else begin
                        bus_req  <= 1'b1;
                        bus_cmd  <= fill_cmd;
                        bus_addr <= addr_q;
                        state    <= BREQ;
                    end
                end
                WB: begin
                    if (bus_done) begin
                        bus_req  <= 1'b0;
                        bus_cmd  <= fill_cmd;
                        bus_addr <= addr_q;
                        state    <= BREQ;
                    end
                end
                BREQ: begin
                    // Entered with bus_req low after a write-back; raise the fill next
                    if (bus_req && bus_done) begin
                        bus_req <= 1'b0;
                        tr_we   <= 1'b1;
                        tr_din  <= {req_tag, rw_q ? ST_M : ST_S};
                        state   <= UPD;
                    end else begin
                        bus_req <= 1'b1;
                    end
                end
                UPD: begin
                    cpu_done <= 1'b1;
                    state    <= IDLE;
                end
                SCMP: begin
                    flush_q <= snp_fl;
                    if (snp_wr) begin
                        tr_we  <= 1'b1;
                        tr_din <= {req_tag, snp_st};
                        state  <= SUPD;
                    end else begin
                        snp_ack <= 1'b1;
                        state   <= IDLE;
                    end
                end
                SUPD: begin
                    snp_ack   <= 1'b1;
                    snp_flush <= flush_q;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_tag_ctrl_a.sv
// tb_cache_tag_ctrl_a: table-driven check of cache_tag_ctrl_a against a behavioural tag RAM
// and a responsive bus agent, plus hand sequences for arbitration and mid-transaction reset.
module tb_cache_tag_ctrl_a;
    localparam logic [1:0] I = 2'b00, S = 2'b01, M = 2'b10;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0, cpu_rw = 1'b0;
    logic [11:0] cpu_addr = '0;
    logic        cpu_done, cpu_hit;
    logic        snp_valid = 1'b0;
    logic [1:0]  snp_cmd = '0;
    logic [11:0] snp_addr = '0;
    logic        snp_ack, snp_flush;
    logic        bus_req;
    logic [1:0]  bus_cmd;
    logic [11:0] bus_addr;
    logic        bus_done = 1'b0;
    logic [2:0]  tr_addr;
    logic [10:0] tr_din;
    logic        tr_we;
    logic [10:0] tr_dout;

    logic [10:0] mem [8];
    logic        pre_we = 1'b0;
    logic [2:0]  pre_idx = '0;
    logic [10:0] pre_val = '0;

    int errors = 0;
    int checks = 0;

    cache_tag_ctrl_a dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr),
        .cpu_done(cpu_done), .cpu_hit(cpu_hit),
        .snp_valid(snp_valid), .snp_cmd(snp_cmd), .snp_addr(snp_addr),
        .snp_ack(snp_ack), .snp_flush(snp_flush),
        .bus_req(bus_req), .bus_cmd(bus_cmd), .bus_addr(bus_addr), .bus_done(bus_done),
        .tr_addr(tr_addr), .tr_din(tr_din), .tr_we(tr_we), .tr_dout(tr_dout)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (pre_we) mem[pre_idx] <= pre_val;
        else if (tr_we) mem[tr_addr] <= tr_din;
        tr_dout <= mem[tr_addr];
    end

    typedef struct {
        logic        snp;
        logic [1:0]  cmd;
        logic [11:0] addr;
        logic [2:0]  pidx;
        logic [10:0] pval;
        int          lat;
        logic        res;
        int          nbus;
        logic [1:0]  c0;
        logic [11:0] a0;
        logic [1:0]  c1;
        logic [11:0] a1;
        int          nwe;
        logic [10:0] din;
    } vec_t;

    vec_t vecs [18];

    function automatic vec_t mk(input logic snp, input logic [1:0] cmd, input logic [11:0] addr,
                                input logic [2:0] pidx, input logic [10:0] pval, input int lat,
                                input logic res, input int nbus, input logic [1:0] c0,
                                input logic [11:0] a0, input logic [1:0] c1, input logic [11:0] a1,
                                input int nwe, input logic [10:0] din);
        vec_t v;
        v.snp = snp; v.cmd = cmd; v.addr = addr; v.pidx = pidx; v.pval = pval; v.lat = lat;
        v.res = res; v.nbus = nbus; v.c0 = c0; v.a0 = a0; v.c1 = c1; v.a1 = a1;
        v.nwe = nwe; v.din = din;
        return v;
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic preload(input logic [2:0] idx, input logic [10:0] val);
        @(negedge clock);
        pre_idx = idx;
        pre_val = val;
        pre_we  = 1'b1;
        @(negedge clock);
        pre_we  = 1'b0;
    endtask

    task automatic run(input vec_t v, input string n);
        int cyc, nb, nw, wt;
        logic prev, got, res, quiet;
        logic [1:0] c [2];
        logic [11:0] a [2];
        logic [10:0] din;
        cyc = 0; nb = 0; nw = 0; wt = 0; prev = 0; got = 0; res = 0; din = '0;
        c[0] = '0; c[1] = '0; a[0] = '0; a[1] = '0;
        preload(v.pidx, v.pval);
        if (v.snp) begin
            snp_valid = 1'b1; snp_cmd = v.cmd; snp_addr = v.addr;
        end else begin
            cpu_req = 1'b1; cpu_rw = v.cmd[0]; cpu_addr = v.addr;
        end
        while (!got && cyc < 60) begin
            @(negedge clock);
            cyc++;
            bus_done = 1'b0;
            if (bus_req && !prev) begin
                if (nb < 2) begin
                    c[nb] = bus_cmd;
                    a[nb] = bus_addr;
                end
                nb++;
                wt = 2;
            end else if (bus_req && wt > 0) begin
                wt--;
                if (wt == 0) bus_done = 1'b1;
            end
            if (tr_we) begin
                nw++;
                din = tr_din;
                chk({n, " we_addr"}, 32'(tr_addr), 32'(v.addr[2:0]));
            end
            if (v.snp ? snp_ack : cpu_done) begin
                got = 1'b1;
                res = v.snp ? snp_flush : cpu_hit;
            end
            prev = bus_req;
        end
        bus_done = 1'b0;
        // Keep the request up through the edge that sees the completion pulse
        @(posedge clock);
        #1;
        snp_valid = 1'b0;
        cpu_req   = 1'b0;
        chk({n, " done"}, 32'(got), 32'd1);
        if (v.lat != 0) chk({n, " latency"}, 32'(cyc), 32'(v.lat));
        chk({n, v.snp ? " flush" : " hit"}, 32'(res), 32'(v.res));
        chk({n, " nbus"}, 32'(nb), 32'(v.nbus));
        if (v.nbus > 0) chk({n, " bus0"}, {18'd0, c[0], a[0]}, {18'd0, v.c0, v.a0});
        if (v.nbus > 1) chk({n, " bus1"}, {18'd0, c[1], a[1]}, {18'd0, v.c1, v.a1});
        chk({n, " nwe"}, 32'(nw), 32'(v.nwe));
        if (v.nwe > 0) chk({n, " din"}, 32'(din), 32'(v.din));
        quiet = 1'b1;
        repeat (3) begin
            @(negedge clock);
            if (cpu_done || snp_ack || bus_req || tr_we) quiet = 1'b0;
        end
        chk({n, " no_reaccept"}, 32'(quiet), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ts, tc, cyc;
        logic hitv, flv;
        vecs[0]  = mk(0, 2'd0, 12'h2D3, 3, {9'h05A, S}, 2, 1, 0, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(0, 2'd1, 12'h2D3, 3, {9'h05A, S}, 0, 0, 1, 2'b10, 12'h2D3, 0, 0, 1, {9'h05A, M});
        vecs[2]  = mk(0, 2'd1, 12'h2D3, 3, {9'h05A, M}, 2, 1, 0, 0, 0, 0, 0, 0, 0);
        vecs[3]  = mk(0, 2'd0, 12'h0FD, 5, {9'h011, M}, 0, 0, 2, 2'b11, 12'h08D, 2'b00, 12'h0FD, 1, {9'h01F, S});
        vecs[4]  = mk(0, 2'd1, 12'h0FD, 5, {9'h011, M}, 0, 0, 2, 2'b11, 12'h08D, 2'b01, 12'h0FD, 1, {9'h01F, M});
        vecs[5]  = mk(0, 2'd1, 12'h0FD, 5, {9'h011, S}, 0, 0, 1, 2'b01, 12'h0FD, 0, 0, 1, {9'h01F, M});
        vecs[6]  = mk(0, 2'd0, 12'h0FD, 5, {9'h01F, 2'b11}, 0, 0, 1, 2'b00, 12'h0FD, 0, 0, 1, {9'h01F, S});
        vecs[7]  = mk(0, 2'd0, 12'h202, 2, {9'h040, I}, 0, 0, 1, 2'b00, 12'h202, 0, 0, 1, {9'h040, S});
        vecs[8]  = mk(0, 2'd0, 12'h0FD, 5, {9'h01F, M}, 2, 1, 0, 0, 0, 0, 0, 0, 0);
        vecs[9]  = mk(1, 2'd0, 12'h2D3, 3, {9'h05A, M}, 3, 1, 0, 0, 0, 0, 0, 1, {9'h05A, S});
        vecs[10] = mk(1, 2'd1, 12'h2D3, 3, {9'h05A, S}, 3, 0, 0, 0, 0, 0, 0, 1, {9'h05A, I});
        vecs[11] = mk(1, 2'd1, 12'h2D3, 3, {9'h05A, M}, 3, 1, 0, 0, 0, 0, 0, 1, {9'h05A, I});
        vecs[12] = mk(1, 2'd2, 12'h2D3, 3, {9'h05A, S}, 3, 0, 0, 0, 0, 0, 0, 1, {9'h05A, I});
        vecs[13] = mk(1, 2'd2, 12'h2D3, 3, {9'h05A, M}, 2, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[14] = mk(1, 2'd0, 12'h2D3, 3, {9'h05A, S}, 2, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[15] = mk(1, 2'd1, 12'h2D3, 3, {9'h011, M}, 2, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[16] = mk(1, 2'd3, 12'h2D3, 3, {9'h05A, M}, 2, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[17] = mk(1, 2'd1, 12'h2D3, 3, {9'h05A, 2'b11}, 2, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 8; i++) mem[i] = '0;
        repeat (3) @(negedge clock);
        chk("reset outputs", {6'd0, cpu_done, cpu_hit, snp_ack, snp_flush, bus_req, bus_cmd,
            bus_addr, tr_addr, tr_we}, 32'd0);
        chk("reset tr_din", 32'(tr_din), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 18; i++) run(vecs[i], $sformatf("v%0d", i));

        // Snoop and CPU request arrive together: snoop first, then the CPU read
        preload(3, {9'h05A, M});
        preload(5, {9'h01F, S});
        snp_valid = 1'b1; snp_cmd = 2'b00; snp_addr = 12'h2D3;
        cpu_req = 1'b1; cpu_rw = 1'b0; cpu_addr = 12'h0FD;
        ts = 0; tc = 0; hitv = 0; flv = 0; cyc = 0;
        while (tc == 0 && cyc < 40) begin
            @(negedge clock);
            cyc++;
            if (snp_ack) begin
                ts = cyc; flv = snp_flush; snp_valid = 1'b0;
            end
            if (cpu_done) begin
                tc = cyc; hitv = cpu_hit; cpu_req = 1'b0;
            end
        end
        snp_valid = 1'b0;
        cpu_req = 1'b0;
        chk("arb snoop_cycle", 32'(ts), 32'd3);
        chk("arb cpu_cycle", 32'(tc), 32'd5);
        chk("arb flush", 32'(flv), 32'd1);
        chk("arb hit", 32'(hitv), 32'd1);
        chk("arb ram_idx3", 32'(mem[3]), 32'({9'h05A, S}));

        // Reset while a bus upgrade is outstanding
        preload(3, {9'h05A, S});
        cpu_req = 1'b1; cpu_rw = 1'b1; cpu_addr = 12'h2D3;
        cyc = 0;
        while (!bus_req && cyc < 20) begin
            @(negedge clock);
            cyc++;
        end
        chk("rst bus_req_seen", 32'(bus_req), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst bus_req_drop", 32'(bus_req), 32'd0);
        chk("rst outputs", {6'd0, cpu_done, cpu_hit, snp_ack, snp_flush, bus_req, bus_cmd,
            bus_addr, tr_addr, tr_we}, 32'd0);
        chk("rst tr_din", 32'(tr_din), 32'd0);
        @(negedge clock);
        cpu_req = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        run(vecs[0], "post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
